// File: rtl/snake_dir_arbiter_pkg.sv
// Shared definitions for the snake steering arbiter: heading encoding,
// relative-turn helpers and the request-source tag used by the arbiter.
package snake_dir_arbiter_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_BTN   = 2'd1,
    REQ_BRAIN = 2'd2
  } req_src_t;

  // Headings are ordered clockwise, so turns are 2-bit wrapping adds.
  function automatic dir_t turn_cw(input dir_t d);
    return d + 2'd1;
  endfunction

  function automatic dir_t turn_ccw(input dir_t d);
    return d - 2'd1;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    return d + 2'd2;
  endfunction

endpackage

// File: rtl/snake_dir_arbiter_if.sv
// Steering bus between the input decoders (master) and the arbiter (slave).
interface snake_dir_arbiter_if
  import snake_dir_arbiter_pkg::*;
#(
  parameter int DROP_CNT_W = 8
);
  logic                  game_tick;
  logic                  brain_en;
  logic                  brain_left;
  logic                  brain_right;
  logic                  btn_up;
  logic                  btn_right;
  logic                  btn_down;
  logic                  btn_left;
  dir_t                  dir;
  logic                  dir_changed;
  logic                  pend_valid;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output game_tick, brain_en, brain_left, brain_right,
    output btn_up, btn_right, btn_down, btn_left,
    input  dir, dir_changed, pend_valid, drop_cnt
  );

  modport slave (
    input  game_tick, brain_en, brain_left, brain_right,
    input  btn_up, btn_right, btn_down, btn_left,
    output dir, dir_changed, pend_valid, drop_cnt
  );
endinterface

// File: rtl/snake_dir_arbiter_btn_rise_detect.sv
// Button rising-edge detector: registers the 4 debounced button levels and
// emits a 1-cycle pulse per button on the cycle its level first goes high.
module btn_rise_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_lvl,
  output logic [3:0] o_rise
);
  logic [3:0] r_lvl;

  // Remember last cycle's level; cleared so a held button re-fires after reset.
  always_ff @(posedge clk) begin
    if (!rst) r_lvl <= 4'b0000;
    else      r_lvl <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_lvl;
endmodule

// File: rtl/snake_dir_arbiter.sv
// Snake steering arbiter: merges relative EEG turn pulses and absolute button
// presses into one buffered turn, commits it on game_tick, rejects reversals
// and counts rejected requests (saturating).
// Optional feature macro: DIR_ARB_LOCKOUT_EN -- after an accepted button turn,
// brain pulses are ignored for LOCKOUT_CYCLES cycles.
module snake_dir_arbiter
  import snake_dir_arbiter_pkg::*;
#(
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd50_000_000,
  parameter int          DROP_CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst,
  snake_dir_arbiter_if.slave  bus
);

  dir_t                  r_dir;
  dir_t                  r_pend;
  logic                  r_pend_valid;
  logic                  r_dir_changed;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [3:0] w_rise;
  logic       w_btn_req;
  dir_t       w_btn_tgt;
  dir_t       w_nxt;
  dir_t       w_base;
  logic       w_brain_ok;
  req_src_t   w_src;
  dir_t       w_tgt;
  logic       w_brain_both;
  logic       w_reject;
  logic       w_accept;
  logic       w_commit;

  btn_rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .i_lvl  ({bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up}),
    .o_rise (w_rise)
  );

`ifdef DIR_ARB_LOCKOUT_EN
  logic [31:0] r_lockout;

  // Brain-ignore window: reloaded by every accepted button turn, counts down to 0.
  always_ff @(posedge clk) begin
    if (!rst)                         r_lockout <= 32'd0;
    else if (w_accept && w_btn_req)   r_lockout <= LOCKOUT_CYCLES - 32'd1;
    else if (r_lockout != 32'd0)      r_lockout <= r_lockout - 32'd1;
  end

  assign w_brain_ok = bus.brain_en && (r_lockout == 32'd0);
`else
  logic w_unused_lockout;
  assign w_unused_lockout = ^LOCKOUT_CYCLES;
  assign w_brain_ok       = bus.brain_en;
`endif

  // Simultaneous button edges resolve UP > RIGHT > DOWN > LEFT; losers vanish.
  always_comb begin
    w_btn_req = 1'b1;
    w_btn_tgt = DIR_UP;
    if      (w_rise[0]) w_btn_tgt = DIR_UP;
    else if (w_rise[1]) w_btn_tgt = DIR_RIGHT;
    else if (w_rise[2]) w_btn_tgt = DIR_DOWN;
    else if (w_rise[3]) w_btn_tgt = DIR_LEFT;
    else                w_btn_req = 1'b0;
  end

  // nxt is the heading the snake will have after this cycle; relative turns
  // apply to the newest intent (pending turn if any, else the current heading).
  assign w_commit = bus.game_tick && r_pend_valid;
  assign w_nxt    = w_commit ? r_pend : r_dir;
  assign w_base   = bus.game_tick ? w_nxt : (r_pend_valid ? r_pend : r_dir);

  // Pick this cycle's single request; a button press silently beats the brain.
  always_comb begin
    w_src        = REQ_NONE;
    w_tgt        = w_btn_tgt;
    w_brain_both = 1'b0;
    if (w_btn_req) begin
      w_src = REQ_BTN;
    end else if (w_brain_ok) begin
      if (bus.brain_left && bus.brain_right) begin
        w_brain_both = 1'b1;
      end else if (bus.brain_right) begin
        w_src = REQ_BRAIN;
        w_tgt = turn_cw(w_base);
      end else if (bus.brain_left) begin
        w_src = REQ_BRAIN;
        w_tgt = turn_ccw(w_base);
      end
    end
  end

  assign w_reject = (w_src != REQ_NONE) && (w_tgt == opposite(w_nxt));
  assign w_accept = (w_src != REQ_NONE) && !w_reject;

  // Pending buffer (1-deep, last wins) and heading commit on game_tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dir         <= DIR_RIGHT;
      r_pend        <= DIR_RIGHT;
      r_pend_valid  <= 1'b0;
      r_dir_changed <= 1'b0;
    end else begin
      r_dir_changed <= w_commit && (r_pend != r_dir);
      if (w_commit) r_dir <= r_pend;
      if (w_accept) begin
        r_pend       <= w_tgt;
        r_pend_valid <= 1'b1;
      end else if (bus.game_tick) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Saturating count of reversals and ambiguous (both-way) brain pulses.
  always_ff @(posedge clk) begin
    if (!rst)
      r_drop_cnt <= '0;
    else if ((w_reject || w_brain_both) && (r_drop_cnt != {DROP_CNT_W{1'b1}}))
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
  end

  assign bus.dir         = r_dir;
  assign bus.dir_changed = r_dir_changed;
  assign bus.pend_valid  = r_pend_valid;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Bench for snake_dir_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_snake_dir_arbiter;
  localparam int LOCK = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  snake_dir_arbiter_if #(.DROP_CNT_W(8)) bus ();

  snake_dir_arbiter #(.LOCKOUT_CYCLES(32'd20), .DROP_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model state
  int m_dir = 1, m_pend = 1, m_pv = 0, m_chg = 0, m_drop = 0, m_lock = 0;
  logic [3:0] m_prev = 4'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: spec rules evaluated with plain integer arithmetic each clock.
  always @(posedge clk) begin : model
    logic [3:0] btn, rise;
    int tgt, nxt, base, have, from_btn, drop, acc;
    btn = {bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up};
    if (!rst) begin
      m_dir <= 1; m_pend <= 1; m_pv <= 0; m_chg <= 0; m_drop <= 0; m_lock <= 0;
      m_prev <= 4'b0;
    end else begin
      rise = btn & ~m_prev;
      nxt  = (bus.game_tick && m_pv != 0) ? m_pend : m_dir;
      base = bus.game_tick ? nxt : ((m_pv != 0) ? m_pend : m_dir);
      have = 0; from_btn = 0; drop = 0; tgt = 0;
      for (int i = 3; i >= 0; i--)
        if (rise[i]) begin have = 1; from_btn = 1; tgt = i; end
      if (!have && bus.brain_en && m_lock == 0) begin
        if (bus.brain_left && bus.brain_right) drop = 1;
        else if (bus.brain_right) begin have = 1; tgt = (base + 1) % 4; end
        else if (bus.brain_left)  begin have = 1; tgt = (base + 3) % 4; end
      end
      acc = (have != 0 && tgt != (nxt + 2) % 4) ? 1 : 0;
      if (have != 0 && acc == 0) drop = 1;
      m_chg <= (nxt != m_dir) ? 1 : 0;
      m_dir <= nxt;
      if (acc != 0) begin m_pend <= tgt; m_pv <= 1; end
      else if (bus.game_tick) m_pv <= 0;
      if (drop != 0 && m_drop < 255) m_drop <= m_drop + 1;
`ifdef DIR_ARB_LOCKOUT_EN
      if (acc != 0 && from_btn != 0) m_lock <= LOCK - 1;
      else if (m_lock > 0) m_lock <= m_lock - 1;
`endif
      m_prev <= btn;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dir",         int'(bus.dir),         m_dir);
      chk("dir_changed", int'(bus.dir_changed), m_chg);
      chk("pend_valid",  int'(bus.pend_valid),  m_pv);
      chk("drop_cnt",    int'(bus.drop_cnt),    m_drop);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus.game_tick = 0; bus.brain_en = 0; bus.brain_left = 0; bus.brain_right = 0;
    bus.btn_up = 0; bus.btn_right = 0; bus.btn_down = 0; bus.btn_left = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic tick();
    bus.game_tick = 1; step(); bus.game_tick = 0;
  endtask

  initial begin
    clr_inputs();
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    // 1: idle with ticks
    chk("rst_dir", int'(bus.dir), 1);
    chk("rst_drop", int'(bus.drop_cnt), 0);
    for (int k = 0; k < 5; k++) begin
      tick(); step(2);
      chk("idle_dir", int'(bus.dir), 1);
      chk("idle_chg", int'(bus.dir_changed), 0);
    end

    // 2: brain_right buffered, then committed
    bus.brain_en = 1;
    bus.brain_right = 1; step(); bus.brain_right = 0;
    step(9);
    chk("t2_pend", int'(bus.pend_valid), 1);
    chk("t2_dir_hold", int'(bus.dir), 1);
    tick();
    chk("t2_dir", int'(bus.dir), 2);
    chk("t2_chg", int'(bus.dir_changed), 1);
    chk("t2_pv_clr", int'(bus.pend_valid), 0);
    step();
    chk("t2_chg_off", int'(bus.dir_changed), 0);

    // 3: reversal rejected, counter saturates
    do_reset();
    bus.btn_left = 1; step(); bus.btn_left = 0;
    chk("t3_pend", int'(bus.pend_valid), 0);
    chk("t3_drop1", int'(bus.drop_cnt), 1);
    step();
    for (int k = 0; k < 300; k++) begin
      bus.btn_left = 1; step(); bus.btn_left = 0; step();
    end
    chk("t3_sat", int'(bus.drop_cnt), 255);

    // 4: last request wins
    do_reset();
    bus.btn_up = 1; step(); bus.btn_up = 0; step();
    tick();
    chk("t4_dir0", int'(bus.dir), 0);
    bus.brain_en = 1;
    bus.brain_left = 1; step(); bus.brain_left = 0; step();
    bus.btn_right = 1; step(); bus.btn_right = 0; step();
    tick();
    chk("t4_dir1", int'(bus.dir), 1);
    chk("t4_chg", int'(bus.dir_changed), 1);

    // 5: button beats brain in the same cycle
    step(2);
    bus.btn_up = 1; bus.brain_right = 1; step();
    bus.btn_up = 0; bus.brain_right = 0;
    chk("t5_pend", int'(bus.pend_valid), 1);
    chk("t5_drop", int'(bus.drop_cnt), 0);
    tick();
    chk("t5_dir", int'(bus.dir), 0);

    // 6: lockout window after a button turn
    do_reset();
    bus.brain_en = 1;
    bus.btn_down = 1; step(); bus.btn_down = 0;
    step(4);
    bus.brain_left = 1; step(); bus.brain_left = 0;
    tick();
`ifdef DIR_ARB_LOCKOUT_EN
    chk("t6_early", int'(bus.dir), 2);
`else
    chk("t6_early", int'(bus.dir), 1);
`endif
    step(18);
    bus.brain_left = 1; step(); bus.brain_left = 0;
    tick();
`ifdef DIR_ARB_LOCKOUT_EN
    chk("t6_late", int'(bus.dir), 1);
`else
    chk("t6_late", int'(bus.dir), 0);
`endif

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      bus.game_tick   = ($urandom_range(0, 7) == 0);
      bus.brain_en    = ($urandom_range(0, 3) != 0);
      bus.brain_left  = ($urandom_range(0, 5) == 0);
      bus.brain_right = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) bus.btn_up    = ~bus.btn_up;
      if ($urandom_range(0, 7) == 0) bus.btn_right = ~bus.btn_right;
      if ($urandom_range(0, 7) == 0) bus.btn_down  = ~bus.btn_down;
      if ($urandom_range(0, 7) == 0) bus.btn_left  = ~bus.btn_left;
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1;
    clr_inputs();
    step(2);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
